dmem_responder: RTL

Responder side of the core's data-memory port: accepts one load/store request at a time from the MEM stage over a valid/ready handshake. It performs the access against an internal word-organised RAM after a programmable number of wait states, then returns read data or an error over a valid/ready response channel. It replaces the zero-latency data memory so the pipeline can be exercised against realistic memory latency and backpressure.

---
 rtl/dmem_responder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Responder side of the core's data-memory port. Accepts one load/store at a
// time over a valid/ready request channel, performs it against an internal
// word-organised RAM after WAIT_CYCLES wait states, and returns load data or an
// error over a valid/ready response channel.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   reset           asynchronous, active-high reset
//   req_valid_i     request present
//   req_ready_o     responder can accept a request (high only in IDLE)
//   req_write_i     1 = store, 0 = load
//   req_addr_i      byte address
//   req_wdata_i     store data, byte/half data taken from the low bits
//   req_size_i      00 = byte, 01 = half, 10 = word, 11 = illegal
//   req_unsigned_i  loads only: 1 = zero-extend, 0 = sign-extend
//   resp_valid_o    response present (high only in RESP)
//   resp_ready_i    core accepts the response
//   resp_rdata_o    extended load data; 0 for stores and errors
//   resp_err_o      misaligned, out of range or illegal size
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Illegal size, misalignment for the access size, or word index past the RAM.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = 1'b0;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = addr[0];
      SZ_WORD: e = (addr[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= DEPTH_WORDS) begin
      e = 1'b1;
    end else begin
      e = e;
    end
    return e;
  endfunction

  // Merge store data into the selected byte lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
      SZ_WORD: r                             = wdata;
      default: r                             = old_word;
    endcase
    return r;
  endfunction

  // Right-justify the selected byte/half and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    r = 32'h0;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic              accept_s;
  logic              commit_s;
  logic              op_write_s;
  logic [31:0]       op_addr_s;
  logic [31:0]       op_wdata_s;
  logic [1:0]        op_size_s;
  logic              op_uns_s;
  logic              op_err_s;
  logic [IDX_W-1:0]  word_idx_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       wr_word_s;
  logic              mem_we_s;

  assign accept_s = (state_q == ST_IDLE) && req_valid_i;

  // With zero wait states the commit edge is the accept edge, so the access
  // uses the live request; otherwise it uses the captured copy.
  assign op_write_s = (state_q == ST_IDLE) ? req_write_i    : wr_q;
  assign op_addr_s  = (state_q == ST_IDLE) ? req_addr_i     : addr_q;
  assign op_wdata_s = (state_q == ST_IDLE) ? req_wdata_i    : wdata_q;
  assign op_size_s  = (state_q == ST_IDLE) ? req_size_i     : size_q;
  assign op_uns_s   = (state_q == ST_IDLE) ? req_unsigned_i : uns_q;
  assign op_err_s   = (state_q == ST_IDLE) ? access_err(req_size_i, req_addr_i) : err_q;

  assign word_idx_s = op_addr_s[IDX_W+1:2];
  assign rd_word_s  = mem_q[word_idx_s];
  assign wr_word_s  = store_merge(rd_word_s, op_wdata_s, op_size_s, op_addr_s[1:0]);
  assign mem_we_s   = commit_s && op_write_s && !op_err_s;

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = rerr_q;

  // Next-state, wait counter and response data at the commit edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 32'd0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 8'd1) begin
          state_d  = ST_RESP;
          cnt_d    = 8'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          rerr_d  = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (commit_s) begin
      rerr_d  = op_err_s;
      rdata_d = (op_err_s || op_write_s) ? 32'h0
                : load_extract(rd_word_s, op_size_s, op_addr_s[1:0], op_uns_s);
    end else begin
      rerr_d = rerr_d;
    end
  end

  // FSM state, counter and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Request capture at acceptance, including the precomputed error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept_s) begin
      wr_q    <= req_write_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      err_q   <= access_err(req_size_i, req_addr_i);
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_idx_s] <= wr_word_s;
    end
  end

endmodule
